// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Architectural zero register: writes to it are discarded.
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_result_fifo.sv
// In-order {dest,data} FIFO for MDU results; exposes per-entry dest/valid for hazard compare.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic [ADDR_W-1:0]                 push_dest,
    input  logic [DATA_W-1:0]                 push_data,
    input  logic                              pop,
    output logic [$clog2(DEPTH):0]            count,
    output logic [ADDR_W-1:0]                 head_dest_c,
    output logic [DATA_W-1:0]                 head_data_c,
    output logic [DEPTH-1:0][ADDR_W-1:0]      entry_dest,
    output logic [DEPTH-1:0]                  entry_valid_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] dest_mem;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_mem <= '0;
            data_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                dest_mem[wr_ptr] <= push_dest;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dest_c = dest_mem[rd_ptr];
    assign head_data_c = data_mem[rd_ptr];
    assign entry_dest  = dest_mem;

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid_c[i] = (CNT_W'(PTR_W'(i) - rd_ptr) < count);
        end
    end

endmodule : wb_result_fifo

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and queued MDU results.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    input  logic                       wb_regwrite,
    input  logic [ADDR_W-1:0]          wb_regdest,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       mdu_valid,
    input  logic [ADDR_W-1:0]          mdu_regdest,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       mdu_ready,
    output logic                       pipe_stall,
    output logic [$clog2(DEPTH):0]     mdu_pending,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]             count;
    logic [ADDR_W-1:0]            head_dest;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_dest;
    logic [DEPTH-1:0]             entry_valid;
    logic [WAIT_W-1:0]            wait_cnt;

    logic wb_req;
    logic fifo_nonempty;
    logic push;
    logic conflict;
    logic starve;
    logic grant_mdu;
    logic grant_wb;

    assign wb_req        = wb_valid & wb_regwrite & (wb_regdest != ADDR_W'(REG_ZERO));
    assign fifo_nonempty = (count != CNT_W'(0));
    assign mdu_ready     = (count < CNT_W'(DEPTH));
    // Results for r0 are acknowledged but never occupy a slot.
    assign push          = mdu_valid & mdu_ready & (mdu_regdest != ADDR_W'(REG_ZERO));
    assign mdu_pending   = count;

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_dest     (mdu_regdest),
        .push_data     (mdu_data),
        .pop           (grant_mdu),
        .count         (count),
        .head_dest_c   (head_dest),
        .head_data_c   (head_data),
        .entry_dest    (entry_dest),
        .entry_valid_c (entry_valid)
    );

    // WAW hazard: an older queued result must land before WB overwrites the same register.
    always_comb begin
        conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_dest[i] == wb_regdest)) begin
                conflict = 1'b1;
            end
        end
        conflict = conflict & wb_req;
    end

    assign starve     = fifo_nonempty & (wait_cnt == WAIT_W'(MAX_WAIT));
    assign grant_mdu  = fifo_nonempty & (~wb_req | conflict | starve);
    assign grant_wb   = wb_req & ~grant_mdu;
    assign pipe_stall = wb_req & grant_mdu;

    // Counts consecutive losses of a non-empty FIFO, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!fifo_nonempty || grant_mdu) begin
            wait_cnt <= '0;
        end else if (grant_wb && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Write-port registers; address/data hold when nobody wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_wb | grant_mdu;
            if (grant_mdu) begin
                rf_waddr <= head_dest;
                rf_wdata <= head_data;
            end else if (grant_wb) begin
                rf_waddr <= wb_regdest;
                rf_wdata <= wb_data;
            end
        end
    end

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, WB path, MDU path, conflict, starvation, full FIFO, mid-drain reset.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_regdest;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_regdest;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_stall;
    logic [1:0]  mdu_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int vec_cnt;
    int miss_cnt;

    wb_port_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_regdest  (wb_regdest),
        .wb_data     (wb_data),
        .mdu_valid   (mdu_valid),
        .mdu_regdest (mdu_regdest),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .pipe_stall  (pipe_stall),
        .mdu_pending (mdu_pending),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wb_set(input logic v, input logic w, input logic [4:0] d, input logic [31:0] x);
        wb_valid    = v;
        wb_regwrite = w;
        wb_regdest  = d;
        wb_data     = x;
    endtask

    task automatic mdu_set(input logic v, input logic [4:0] d, input logic [31:0] x);
        mdu_valid   = v;
        mdu_regdest = d;
        mdu_data    = x;
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        rst_n    = 1'b0;
        wb_set(1'b0, 1'b0, 5'd0, 32'h0);
        mdu_set(1'b0, 5'd0, 32'h0);

        // Reset state
        tick();
        tick();
        chk("rst_rf_we",    32'(rf_we),       32'd0);
        chk("rst_waddr",    32'(rf_waddr),    32'd0);
        chk("rst_wdata",    rf_wdata,         32'd0);
        chk("rst_ready",    32'(mdu_ready),   32'd1);
        chk("rst_pending",  32'(mdu_pending), 32'd0);
        chk("rst_stall",    32'(pipe_stall),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rf_we",   32'(rf_we),       32'd0);

        // WB write with empty FIFO: one-cycle latency, no stall
        wb_set(1'b1, 1'b1, 5'd8, 32'h1234);
        settle();
        chk("wb_stall",     32'(pipe_stall),  32'd0);
        tick();
        chk("wb_we",        32'(rf_we),       32'd1);
        chk("wb_waddr",     32'(rf_waddr),    32'd8);
        chk("wb_wdata",     rf_wdata,         32'h1234);
        wb_set(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("hold_we",      32'(rf_we),       32'd0);
        chk("hold_waddr",   32'(rf_waddr),    32'd8);
        chk("hold_wdata",   rf_wdata,         32'h1234);

        // MDU push r3, drained while WB carries a non-writing instruction
        mdu_set(1'b1, 5'd3, 32'hAAAA);
        settle();
        chk("mdu_ready1",   32'(mdu_ready),   32'd1);
        tick();
        mdu_set(1'b0, 5'd0, 32'h0);
        wb_set(1'b1, 1'b0, 5'd3, 32'hDEAD);
        chk("mdu_pend1",    32'(mdu_pending), 32'd1);
        chk("mdu_nowr_yet", 32'(rf_we),       32'd0);
        settle();
        chk("nowr_stall",   32'(pipe_stall),  32'd0);
        tick();
        wb_set(1'b0, 1'b0, 5'd0, 32'h0);
        chk("mdu_we",       32'(rf_we),       32'd1);
        chk("mdu_waddr",    32'(rf_waddr),    32'd3);
        chk("mdu_wdata",    rf_wdata,         32'hAAAA);
        chk("mdu_pend0",    32'(mdu_pending), 32'd0);

        // Push to r0 is swallowed
        mdu_set(1'b1, 5'd0, 32'h1);
        tick();
        mdu_set(1'b0, 5'd0, 32'h0);
        chk("r0_pending",   32'(mdu_pending), 32'd0);
        chk("r0_we_a",      32'(rf_we),       32'd0);
        tick();
        chk("r0_we_b",      32'(rf_we),       32'd0);
        chk("r0_waddr",     32'(rf_waddr),    32'd3);

        // Destination conflict: queued r5 lands before WB r5
        mdu_set(1'b1, 5'd5, 32'h55);
        tick();
        mdu_set(1'b0, 5'd0, 32'h0);
        wb_set(1'b1, 1'b1, 5'd5, 32'h77);
        settle();
        chk("cf_stall",     32'(pipe_stall),  32'd1);
        tick();
        chk("cf_mdu_waddr", 32'(rf_waddr),    32'd5);
        chk("cf_mdu_wdata", rf_wdata,         32'h55);
        chk("cf_mdu_we",    32'(rf_we),       32'd1);
        settle();
        chk("cf_stall_off", 32'(pipe_stall),  32'd0);
        tick();
        chk("cf_wb_wdata",  rf_wdata,         32'h77);
        chk("cf_wb_waddr",  32'(rf_waddr),    32'd5);
        wb_set(1'b0, 1'b0, 5'd0, 32'h0);

        // Starvation, run twice to confirm the wait counter restarts from zero
        for (int r = 0; r < 2; r++) begin
            mdu_set(1'b1, 5'(9 + r * 12), 32'h99 + 32'(r));
            tick();
            mdu_set(1'b0, 5'd0, 32'h0);
            for (int k = 0; k < 4; k++) begin
                wb_set(1'b1, 1'b1, 5'(10 + k), 32'h100 + 32'(k));
                settle();
                chk("sv_stall_off", 32'(pipe_stall), 32'd0);
                tick();
                chk("sv_wb_waddr",  32'(rf_waddr),   32'(10 + k));
                chk("sv_wb_wdata",  rf_wdata,        32'h100 + 32'(k));
                chk("sv_pending",   32'(mdu_pending), 32'd1);
            end
            wb_set(1'b1, 1'b1, 5'd14, 32'h200);
            settle();
            chk("sv_stall_on",  32'(pipe_stall),  32'd1);
            tick();
            chk("sv_mdu_waddr", 32'(rf_waddr),    32'(9 + r * 12));
            chk("sv_mdu_wdata", rf_wdata,         32'h99 + 32'(r));
            chk("sv_pend0",     32'(mdu_pending), 32'd0);
            settle();
            chk("sv_held_stall", 32'(pipe_stall), 32'd0);
            tick();
            chk("sv_held_waddr", 32'(rf_waddr),   32'd14);
            wb_set(1'b0, 1'b0, 5'd0, 32'h0);
        end

        // Fill FIFO to DEPTH, extra offer ignored
        mdu_set(1'b1, 5'd6, 32'h66);
        tick();
        wb_set(1'b1, 1'b1, 5'd1, 32'h11);
        mdu_set(1'b1, 5'd7, 32'h67);
        settle();
        chk("fill_stall1",  32'(pipe_stall),  32'd0);
        tick();
        wb_set(1'b1, 1'b1, 5'd2, 32'h22);
        mdu_set(1'b1, 5'd8, 32'h68);
        settle();
        chk("full_ready",   32'(mdu_ready),   32'd0);
        chk("full_pending", 32'(mdu_pending), 32'd2);
        chk("full_stall",   32'(pipe_stall),  32'd0);
        tick();
        wb_set(1'b0, 1'b0, 5'd0, 32'h0);
        mdu_set(1'b0, 5'd0, 32'h0);
        chk("full_waddr",   32'(rf_waddr),    32'd2);
        chk("full_pend2",   32'(mdu_pending), 32'd2);
        tick();
        chk("drain_waddr",  32'(rf_waddr),    32'd6);
        chk("drain_wdata",  rf_wdata,         32'h66);
        chk("drain_pend1",  32'(mdu_pending), 32'd1);

        // Reset mid-drain discards r7
        rst_n = 1'b0;
        settle();
        chk("mrst_we",      32'(rf_we),       32'd0);
        chk("mrst_pending", 32'(mdu_pending), 32'd0);
        chk("mrst_ready",   32'(mdu_ready),   32'd1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_we",      32'(rf_we),       32'd0);
            chk("post_pending", 32'(mdu_pending), 32'd0);
        end
        chk("post_waddr",   32'(rf_waddr),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule : tb_wb_port_arbiter
